ltc2308_emu: RTL and testbench

LTC2308_EMU -- requirements
Module: ltc2308_emu

---
 rtl/ltc2308_emu.sv | 202 ++++++++++++++++++++
 tb/tb_ltc2308_emu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_emu.sv
// LTC2308 ADC emulator: replays ch_data over the SPI-like CONVST/SCK/SDI/SDO pins with a configurable conversion time.
// Optional LTC2308_EMU_STATS_EN adds frame_count/err_count outputs.
module ltc2308_emu #(
  parameter int CONV_CYCLES = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] ch_data,
  input  logic        ADC_CONVST,
  input  logic        ADC_SCK,
  input  logic        ADC_SDI,
  output logic        ADC_SDO,
  output logic [5:0]  cfg_word,
  output logic        frame_done,
  output logic        proto_err
`ifdef LTC2308_EMU_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
`endif
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_CONV   = 2'd1;
  localparam logic [1:0]  ST_READY  = 2'd2;
  localparam logic [1:0]  ST_SHIFT  = 2'd3;
  localparam logic [2:0]  FILL_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [11:0] CONV_LAST = 12'(CONV_CYCLES - 1);
  localparam logic [5:0]  CFG_RST   = 6'b100010;

  logic [SYNC_STAGES-1:0] convst_sync_q, convst_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic        convst_prev_q, convst_prev_d, sck_prev_q, sck_prev_d;
  logic [2:0]  fill_q, fill_d;
  logic [1:0]  state_q, state_d;
  logic [11:0] conv_cnt_q, conv_cnt_d;
  logic [3:0]  fall_q, fall_d;
  logic [2:0]  bits_q, bits_d;
  logic [5:0]  sr_q, sr_d;
  logic [11:0] result_q, result_d;
  logic [5:0]  cfg_q, cfg_d;
  logic        done_q, done_d, err_q, err_d;

  logic        live, convst_lvl, sck_lvl, sdi_lvl;
  logic        conv_rise, sck_rise, sck_fall, sck_edge;
  logic [2:0]  sel_a, sel_b;
  logic [11:0] a_val, b_val, conv_val;
  logic [12:0] diff;

  // Edges are only trusted once every synchronizer stage holds a live pin sample.
  always_comb begin
    convst_sync_d = {convst_sync_q[SYNC_STAGES-2:0], ADC_CONVST};
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], ADC_SCK};
    sdi_sync_d    = {sdi_sync_q[SYNC_STAGES-2:0], ADC_SDI};
    convst_lvl    = convst_sync_q[SYNC_STAGES-1];
    sck_lvl       = sck_sync_q[SYNC_STAGES-1];
    sdi_lvl       = sdi_sync_q[SYNC_STAGES-1];
    convst_prev_d = convst_lvl;
    sck_prev_d    = sck_lvl;
    fill_d        = (fill_q == FILL_DONE) ? fill_q : fill_q + 3'd1;
    live          = (fill_q == FILL_DONE);
    conv_rise     = live & convst_lvl & ~convst_prev_q;
    sck_rise      = live & sck_lvl & ~sck_prev_q;
    sck_fall      = live & ~sck_lvl & sck_prev_q;
    sck_edge      = sck_rise | sck_fall;
  end

  // Channel select and output coding; sel_a doubles as the single-ended index.
  always_comb begin
    sel_a = {cfg_q[3], cfg_q[2], cfg_q[4]};
    sel_b = {cfg_q[3], cfg_q[2], ~cfg_q[4]};
    a_val = ch_data[32'(sel_a) * 12 +: 12];
    b_val = ch_data[32'(sel_b) * 12 +: 12];
    diff  = {1'b0, a_val} - {1'b0, b_val};
    conv_val = '0;
    if (cfg_q[5]) begin
      conv_val = cfg_q[1] ? a_val : (a_val ^ 12'h800);
    end else if (cfg_q[1]) begin
      conv_val = diff[12] ? 12'h000 : diff[11:0];
    end else if (diff[12] && !diff[11]) begin
      conv_val = 12'h800;
    end else if (!diff[12] && diff[11]) begin
      conv_val = 12'h7FF;
    end else begin
      conv_val = diff[11:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    fall_d     = fall_q;
    bits_d     = bits_q;
    sr_d       = sr_q;
    result_d   = result_q;
    cfg_d      = cfg_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (conv_rise) begin
      state_d    = ST_CONV;
      conv_cnt_d = '0;
      fall_d     = '0;
      bits_d     = '0;
      result_d   = conv_val;
      err_d      = sck_edge || (state_q == ST_SHIFT && fall_q < 4'd12);
    end else begin
      if (state_q == ST_CONV) begin
        if (conv_cnt_q == CONV_LAST) state_d = ST_READY;
        else conv_cnt_d = conv_cnt_q + 12'd1;
      end
      if (sck_edge) begin
        if (state_q == ST_CONV || convst_lvl) begin
          err_d = 1'b1;
        end else if (state_q == ST_READY || state_q == ST_SHIFT) begin
          state_d = ST_SHIFT;
          if (sck_rise && bits_q < 3'd6) begin
            sr_d   = {sr_q[4:0], sdi_lvl};
            bits_d = bits_q + 3'd1;
          end
          if (sck_fall && fall_q < 4'd12) begin
            fall_d = fall_q + 4'd1;
            if (fall_q == 4'd11) begin
              done_d = 1'b1;
              if (bits_q == 3'd6) cfg_d = sr_q;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      convst_sync_q <= '0;
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      convst_prev_q <= 1'b0;
      sck_prev_q    <= 1'b0;
      fill_q        <= '0;
      state_q       <= ST_IDLE;
      conv_cnt_q    <= '0;
      fall_q        <= '0;
      bits_q        <= '0;
      sr_q          <= '0;
      result_q      <= '0;
      cfg_q         <= CFG_RST;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      convst_sync_q <= convst_sync_d;
      sck_sync_q    <= sck_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      convst_prev_q <= convst_prev_d;
      sck_prev_q    <= sck_prev_d;
      fill_q        <= fill_d;
      state_q       <= state_d;
      conv_cnt_q    <= conv_cnt_d;
      fall_q        <= fall_d;
      bits_q        <= bits_d;
      sr_q          <= sr_d;
      result_q      <= result_d;
      cfg_q         <= cfg_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    ADC_SDO = 1'b0;
    if ((state_q == ST_READY || state_q == ST_SHIFT) && fall_q < 4'd12)
      ADC_SDO = result_q[4'd11 - fall_q];
  end

  assign cfg_word   = cfg_q;
  assign frame_done = done_q;
  assign proto_err  = err_q;

`ifdef LTC2308_EMU_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, done_q};
    err_cnt_d   = err_cnt_q + {15'd0, err_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ltc2308_emu.sv
// Bench for ltc2308_emu: directed protocol scenarios plus random frames against an arithmetic reference model.
module tb_ltc2308_emu;
  localparam int CONV_CYCLES = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] ch_data;
  logic        convst, sck, sdi;
  logic        sdo;
  logic [5:0]  cfg_word;
  logic        frame_done, proto_err;
`ifdef LTC2308_EMU_STATS_EN
  logic [15:0] frame_count, err_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  logic [11:0] ch [8];
  logic [5:0]  cur_cfg;
  logic [11:0] exp_res;
  logic [15:0] rd_bits;
  logic [11:0] rd_word;

  always #5 clk = ~clk;

  ltc2308_emu #(.CONV_CYCLES(CONV_CYCLES), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data),
    .ADC_CONVST(convst), .ADC_SCK(sck), .ADC_SDI(sdi), .ADC_SDO(sdo),
    .cfg_word(cfg_word), .frame_done(frame_done), .proto_err(proto_err)
`ifdef LTC2308_EMU_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (proto_err === 1'b1) pe_cnt++;
  end

  // Reference conversion from the datasheet rules, in plain integer arithmetic.
  function automatic logic [11:0] model(input logic [5:0] cfg);
    int a, b, d, idx, p;
    if (cfg[5]) begin
      idx = 4 * int'(cfg[3]) + 2 * int'(cfg[2]) + int'(cfg[4]);
      d = int'(ch[idx]);
      if (!cfg[1]) d = (d + 2048) % 4096;
    end else begin
      p = 2 * int'(cfg[3]) + int'(cfg[2]);
      a = int'(ch[2 * p + int'(cfg[4])]);
      b = int'(ch[2 * p + 1 - int'(cfg[4])]);
      d = a - b;
      if (cfg[1]) begin
        if (d < 0) d = 0;
      end else begin
        if (d > 2047) d = 2047;
        if (d < -2048) d = -2048;
        if (d < 0) d = d + 4096;
      end
    end
    return 12'(d);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_ch();
    for (int i = 0; i < 8; i++) ch_data[12*i +: 12] = ch[i];
  endtask

  task automatic start_conv();
    exp_res = model(cur_cfg);
    convst = 1'b1;
    step(3);
    convst = 1'b0;
  endtask

  task automatic do_conv();
    start_conv();
    step(CONV_CYCLES + 8);
  endtask

  task automatic sck_pulse();
    sck = 1'b1;
    step(4);
    sck = 1'b0;
    step(4);
  endtask

  task automatic frame(input logic [5:0] cfg_tx, input int n);
    rd_bits = '0;
    for (int i = 0; i < n; i++) begin
      rd_bits[i] = sdo;
      sdi = (i < 6) ? cfg_tx[5-i] : 1'b0;
      step(1);
      sck_pulse();
    end
    sdi = 1'b0;
    for (int k = 0; k < 12; k++) rd_word[11-k] = rd_bits[k];
  endtask

  task automatic full_frame(input string tag, input logic [5:0] cfg_tx);
    int fd0, pe0;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    frame(cfg_tx, 12);
    chk({tag, "_word"}, 32'(rd_word), 32'(exp_res));
    chk({tag, "_done"}, fd_cnt - fd0, 1);
    chk({tag, "_err"}, pe_cnt - pe0, 0);
    cur_cfg = cfg_tx;
    chk({tag, "_cfg"}, 32'(cfg_word), 32'(cur_cfg));
  endtask

  initial begin
    int fd0, pe0;
    logic [5:0] cfg_tx;
    rst = 1'b0; convst = 1'b1; sck = 1'b0; sdi = 1'b0;
    for (int i = 0; i < 8; i++) ch[i] = 12'(i * 273);
    set_ch();
    cur_cfg = 6'b100010;
    step(4);
    chk("rst_sdo", 32'(sdo), 0);
    chk("rst_cfg", 32'(cfg_word), 32'h22);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(proto_err), 0);

    // CONVST held high across reset release must not look like a rising edge.
    rst = 1'b1;
    step(8);
    convst = 1'b0;
    step(8);
    fd0 = fd_cnt; pe0 = pe_cnt;
    sck_pulse();
    step(4);
    chk("fill_err", pe_cnt - pe0, 0);
    chk("fill_done", fd_cnt - fd0, 0);

    ch[0] = 12'h100; ch[1] = 12'h300; ch[3] = 12'hA5C;
    set_ch();
    do_conv(); full_frame("se_ch0", 6'b110110);
    chk("se_ch0_lit", 32'(rd_word), 32'h100);
    do_conv(); full_frame("se_uni", 6'b110100);
    chk("se_uni_lit", 32'(rd_word), 32'hA5C);
    do_conv(); full_frame("se_bip", 6'b000010);
    chk("se_bip_lit", 32'(rd_word), 32'h25C);
    do_conv(); full_frame("diff_uni", 6'b000000);
    chk("diff_uni_lit", 32'(rd_word), 32'h000);
    do_conv(); full_frame("diff_bip", 6'b110110);
    chk("diff_bip_lit", 32'(rd_word), 32'hE00);

    // Abort after 5 falls: CONVST restarts, cfg stays.
    do_conv();
    frame(6'b001100, 5);
    chk("abort_bits", 32'(rd_word[11:7]), 32'(exp_res[11:7]));
    pe0 = pe_cnt;
    start_conv();
    step(8);
    chk("abort_err", pe_cnt - pe0, 1);
    chk("abort_cfg", 32'(cfg_word), 32'(cur_cfg));
    step(CONV_CYCLES);
    full_frame("after_abort", cur_cfg);

    // 14 SCK pulses: the extra bits read 0 and raise no error.
    do_conv();
    fd0 = fd_cnt; pe0 = pe_cnt;
    frame(cur_cfg, 14);
    chk("long_word", 32'(rd_word), 32'(exp_res));
    chk("long_tail", 32'(rd_bits[13:12]), 0);
    chk("long_done", fd_cnt - fd0, 1);
    chk("long_err", pe_cnt - pe0, 0);

    // SCK during conversion is flagged per edge and ignored.
    start_conv();
    step(10);
    pe0 = pe_cnt;
    sck_pulse();
    step(CONV_CYCLES);
    chk("conv_sck_err", pe_cnt - pe0, 2);
    full_frame("after_conv_sck", 6'b100010);

    // SCK while CONVST is high, after conversion has finished.
    exp_res = model(cur_cfg);
    convst = 1'b1;
    step(CONV_CYCLES + 10);
    pe0 = pe_cnt;
    sck_pulse();
    chk("cvh_sck_err", pe_cnt - pe0, 2);
    convst = 1'b0;
    step(4);
    full_frame("after_cvh", 6'b100010);

    // Reset in the middle of a frame.
    for (int i = 0; i < 8; i++) ch[i] = 12'hFFF;
    set_ch();
    do_conv();
    frame(6'b000111, 5);
    chk("pre_rst_sdo", 32'(sdo), 32'(exp_res[6]));
    rst = 1'b0;
    step(3);
    chk("mid_rst_sdo", 32'(sdo), 0);
    chk("mid_rst_cfg", 32'(cfg_word), 32'h22);
    chk("mid_rst_done", 32'(frame_done), 0);
    rst = 1'b1;
    cur_cfg = 6'b100010;
    step(6);
    ch[0] = 12'h3C7;
    set_ch();
    do_conv(); full_frame("post_rst", 6'b100010);
    chk("post_rst_lit", 32'(rd_word), 32'h3C7);

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 8; i++) ch[i] = 12'($urandom_range(0, 4095));
      set_ch();
      cfg_tx = 6'($urandom_range(0, 63));
      do_conv();
      full_frame("rand", cfg_tx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
